// File: rtl/pulse_gen_pkg.sv
//------------------------------------------------------------------------------
// Module   : pulse_gen_pkg
// Brief    : Shared widths, FSM states and constants for the pulse-train generator.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package pulse_gen_pkg;

  localparam int CNT_W_DFLT = 8;
  localparam int DIV_W_DFLT = 16;
  localparam int MIN_PHASE  = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2,
    FIN  = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/pulse_train_gen_phase_timer.sv
//------------------------------------------------------------------------------
// Module   : phase_timer
// Brief    : Loadable down-counter with enable and zero flag; times one phase.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module phase_timer
  import pulse_gen_pkg::*;
#(
  parameter int DIV_W = DIV_W_DFLT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic             i_en,
  input  logic [DIV_W-1:0] i_load_val,
  output logic             o_zero
);

  logic [DIV_W-1:0] r_cnt;

  // Load wins over counting so a phase entry always starts from a fresh value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - DIV_W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/pulse_train_gen.sv
//------------------------------------------------------------------------------
// Module   : pulse_train_gen
// Brief    : Burst/continuous pulse-train generator with gate window and count.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pulse_train_gen
  import pulse_gen_pkg::*;
#(
  parameter int CNT_W = CNT_W_DFLT,
  parameter int DIV_W = DIV_W_DFLT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic             i_continuous,
  input  logic [CNT_W-1:0] i_pulse_count,
  input  logic [DIV_W-1:0] i_high_cycles,
  input  logic [DIV_W-1:0] i_low_cycles,
  output logic             o_sig_out,
  output logic             o_gate_out,
  output logic             o_busy,
  output logic             o_done,
  output logic [CNT_W-1:0] o_pulses_sent
);

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_count;
  logic [DIV_W-1:0] r_high;
  logic [DIV_W-1:0] r_low;
  logic             r_cont;
  logic [CNT_W-1:0] r_pulses_sent;
  logic             r_sig_out;
  logic             r_gate_out;
  logic             r_busy;
  logic             r_done;

  logic             w_launch;
  logic             w_inc_pulse;
  logic             w_timer_load;
  logic [DIV_W-1:0] w_timer_val;
  logic             w_timer_en;
  logic             w_timer_zero;
  logic [DIV_W-1:0] w_high_eff;
  logic [DIV_W-1:0] w_low_eff;
  logic             w_in_burst;

  // Zero-length phases are stretched to one clock.
  assign w_high_eff = (i_high_cycles == '0) ? DIV_W'(MIN_PHASE) : i_high_cycles;
  assign w_low_eff  = (i_low_cycles  == '0) ? DIV_W'(MIN_PHASE) : i_low_cycles;

  assign w_timer_en = (r_state == HIGH) || (r_state == LOW);

  phase_timer #(
    .DIV_W (DIV_W)
  ) u_phase_timer (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_timer_load),
    .i_en       (w_timer_en),
    .i_load_val (w_timer_val),
    .o_zero     (w_timer_zero)
  );

  always_comb begin
    w_next_state = r_state;
    w_launch     = 1'b0;
    w_inc_pulse  = 1'b0;
    w_timer_load = 1'b0;
    w_timer_val  = '0;
    case (r_state)
      IDLE: begin
        if (i_start && !i_abort) begin
          w_launch = 1'b1;
          if (!i_continuous && (i_pulse_count == '0)) begin
            w_next_state = FIN;
          end else begin
            w_next_state = HIGH;
            w_timer_load = 1'b1;
            w_timer_val  = w_high_eff - DIV_W'(1);
          end
        end
      end
      HIGH: begin
        if (i_abort) begin
          w_next_state = IDLE;
        end else if (w_timer_zero) begin
          w_next_state = LOW;
          w_inc_pulse  = 1'b1;
          w_timer_load = 1'b1;
          w_timer_val  = r_low - DIV_W'(1);
        end
      end
      LOW: begin
        if (i_abort) begin
          w_next_state = IDLE;
        end else if (w_timer_zero) begin
          // pulses_sent already counts the pulse finishing in this phase.
          if (!r_cont && (r_pulses_sent == r_count)) begin
            w_next_state = FIN;
          end else begin
            w_next_state = HIGH;
            w_timer_load = 1'b1;
            w_timer_val  = r_high - DIV_W'(1);
          end
        end
      end
      FIN: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  assign w_in_burst = (w_next_state == HIGH) || (w_next_state == LOW);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_count       <= '0;
      r_high        <= '0;
      r_low         <= '0;
      r_cont        <= 1'b0;
      r_pulses_sent <= '0;
      r_sig_out     <= 1'b0;
      r_gate_out    <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_sig_out  <= (w_next_state == HIGH);
      r_gate_out <= w_in_burst;
      r_busy     <= w_in_burst;
      r_done     <= (w_next_state == FIN);
      if (w_launch) begin
        r_count       <= i_pulse_count;
        r_high        <= w_high_eff;
        r_low         <= w_low_eff;
        r_cont        <= i_continuous;
        r_pulses_sent <= '0;
      end else if (w_inc_pulse) begin
        r_pulses_sent <= r_pulses_sent + CNT_W'(1);
      end
    end
  end

  assign o_sig_out     = r_sig_out;
  assign o_gate_out    = r_gate_out;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_pulses_sent = r_pulses_sent;

endmodule

`default_nettype wire

// File: tb/tb_pulse_train_gen.sv
//------------------------------------------------------------------------------
// Module   : tb_pulse_train_gen
// Brief    : Self-checking bench with a closed-form burst model and directed pins.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_pulse_train_gen;

  logic        clk;
  logic        reset;
  logic        i_start;
  logic        i_abort;
  logic        i_continuous;
  logic [7:0]  i_pulse_count;
  logic [15:0] i_high_cycles;
  logic [15:0] i_low_cycles;
  logic        o_sig_out;
  logic        o_gate_out;
  logic        o_busy;
  logic        o_done;
  logic [7:0]  o_pulses_sent;

  pulse_train_gen #(
    .CNT_W (8),
    .DIV_W (16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .i_start       (i_start),
    .i_abort       (i_abort),
    .i_continuous  (i_continuous),
    .i_pulse_count (i_pulse_count),
    .i_high_cycles (i_high_cycles),
    .i_low_cycles  (i_low_cycles),
    .o_sig_out     (o_sig_out),
    .o_gate_out    (o_gate_out),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_pulses_sent (o_pulses_sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: a burst is a cycle offset k from launch; outputs are closed-form in k.
  bit         m_on;
  bit         m_cont;
  int         m_k, m_N, m_H, m_L, m_P;
  logic       e_sig, e_gate, e_busy, e_done;
  logic [7:0] e_ps;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_on = 1'b0;
      e_sig = 1'b0; e_gate = 1'b0; e_busy = 1'b0; e_done = 1'b0;
      e_ps = 8'd0;
    end else begin
      if (m_on) begin
        if (i_abort) m_on = 1'b0;
        else if (!m_cont && m_k == m_N * m_P + 1) m_on = 1'b0;
        else m_k++;
      end else if (i_start && !i_abort) begin
        m_N    = int'(i_pulse_count);
        m_H    = (i_high_cycles == 16'd0) ? 1 : int'(i_high_cycles);
        m_L    = (i_low_cycles == 16'd0) ? 1 : int'(i_low_cycles);
        m_P    = m_H + m_L;
        m_cont = i_continuous;
        m_k    = 1;
        m_on   = 1'b1;
      end
      if (m_on) begin
        e_ps = 8'(((m_k - 1) / m_P) + ((((m_k - 1) % m_P) >= m_H) ? 1 : 0));
        if (!m_cont && m_k == m_N * m_P + 1) begin
          e_sig = 1'b0; e_gate = 1'b0; e_busy = 1'b0; e_done = 1'b1;
        end else begin
          e_sig  = (((m_k - 1) % m_P) < m_H);
          e_gate = 1'b1; e_busy = 1'b1; e_done = 1'b0;
        end
      end else begin
        e_sig = 1'b0; e_gate = 1'b0; e_busy = 1'b0; e_done = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en)
      chk("cycle", 32'({o_sig_out, o_gate_out, o_busy, o_done, o_pulses_sent}),
          32'({e_sig, e_gate, e_busy, e_done, e_ps}));
  end

  // Leaves the bench at the negedge of cycle T+1.
  task automatic go(input int n, input int h, input int l, input bit c);
    @(negedge clk);
    i_pulse_count = 8'(n);
    i_high_cycles = 16'(h);
    i_low_cycles  = 16'(l);
    i_continuous  = c;
    i_abort       = 1'b0;
    i_start       = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  logic [14:0] sig_bits;
  int          done_at;
  int          gate_cnt;
  bit          any_rise;
  bit          saw_done;

  initial begin
    reset = 1'b1;
    i_start = 1'b0; i_abort = 1'b0; i_continuous = 1'b0;
    i_pulse_count = 8'd0; i_high_cycles = 16'd0; i_low_cycles = 16'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_state", 32'({o_sig_out, o_gate_out, o_busy, o_done, o_pulses_sent}), 32'd0);
    chk_en = 1'b1;

    // N=3 H=2 L=3
    go(3, 2, 3, 1'b0);
    sig_bits = '0; gate_cnt = 0; done_at = 0;
    for (int k = 1; k <= 17; k++) begin
      if (k <= 15) sig_bits = {sig_bits[13:0], o_sig_out};
      gate_cnt += int'(o_gate_out);
      if (o_done) done_at = k;
      @(negedge clk);
    end
    chk("t1_sig_pattern", 32'(sig_bits), 32'h6318);
    chk("t1_gate_len", 32'(gate_cnt), 32'd15);
    chk("t1_done_at", 32'(done_at), 32'd16);
    chk("t1_pulses", 32'(o_pulses_sent), 32'd3);

    // N=0
    go(0, 5, 5, 1'b0);
    done_at = 0; any_rise = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      if (o_sig_out || o_gate_out || o_busy) any_rise = 1'b1;
      if (o_done) done_at = k;
      @(negedge clk);
    end
    chk("t2_done_at", 32'(done_at), 32'd1);
    chk("t2_no_rise", 32'(any_rise), 32'd0);

    // N=4 H=L=0 -> square wave, period 2
    go(4, 0, 0, 1'b0);
    sig_bits = '0; done_at = 0;
    for (int k = 1; k <= 11; k++) begin
      if (k <= 8) sig_bits = {sig_bits[13:0], o_sig_out};
      if (o_done) done_at = k;
      @(negedge clk);
    end
    chk("t3_sig_pattern", 32'(sig_bits), 32'h00AA);
    chk("t3_done_at", 32'(done_at), 32'd9);

    // N=5 H=L=4, ignored restart at T+5, abort at T+10
    go(5, 4, 4, 1'b0);
    saw_done = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (o_done) saw_done = 1'b1;
      if (k == 11) begin
        chk("t4_idle_after_abort", 32'({o_sig_out, o_gate_out, o_busy}), 32'd0);
        chk("t4_pulses", 32'(o_pulses_sent), 32'd1);
      end
      i_start = (k == 5);
      i_abort = (k == 10);
      @(negedge clk);
    end
    i_start = 1'b0; i_abort = 1'b0;
    chk("t4_no_done", 32'(saw_done), 32'd0);

    // continuous, H=L=1, 300 pulses then abort
    go(3, 1, 1, 1'b1);
    saw_done = 1'b0;
    for (int k = 1; k <= 604; k++) begin
      if (o_done) saw_done = 1'b1;
      if (k == 601) chk("t5_pulses_wrap", 32'(o_pulses_sent), 32'd44);
      i_abort = (k == 600);
      @(negedge clk);
    end
    i_abort = 1'b0;
    chk("t5_no_done", 32'(saw_done), 32'd0);

    // async reset mid-HIGH, then a clean burst
    go(2, 5, 5, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1 chk("t6_async_reset", 32'({o_sig_out, o_gate_out, o_busy, o_done, o_pulses_sent}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    go(2, 3, 2, 1'b0);
    done_at = 0;
    for (int k = 1; k <= 13; k++) begin
      if (o_done) done_at = k;
      @(negedge clk);
    end
    chk("t6_done_at", 32'(done_at), 32'd11);
    chk("t6_pulses", 32'(o_pulses_sent), 32'd2);

    // randomized bursts with restarts, aborts and config churn
    for (int it = 0; it < 30; it++) begin
      int  n, h, l, used;
      bit  c;
      n = int'($urandom_range(0, 6));
      h = int'($urandom_range(0, 4));
      l = int'($urandom_range(0, 4));
      c = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        i_start = 1'b1; i_abort = 1'b1;
        @(negedge clk);
        i_start = 1'b0; i_abort = 1'b0;
      end
      go(n, h, l, c);
      used = 0;
      while (m_on && used < 400) begin
        i_start = ($urandom_range(0, 7) == 0);
        i_abort = c ? (used >= 40 || $urandom_range(0, 29) == 0) : ($urandom_range(0, 39) == 0);
        i_pulse_count = 8'($urandom_range(0, 255));
        i_high_cycles = 16'($urandom_range(0, 9));
        i_low_cycles  = 16'($urandom_range(0, 9));
        i_continuous  = 1'($urandom_range(0, 1));
        @(negedge clk);
        used++;
      end
      i_start = 1'b0; i_abort = 1'b0;
      chk("rand_burst_ended", 32'(m_on), 32'd0);
      repeat (2) @(negedge clk);
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
